pipe_ctrl: RTL and testbench

//  Central pipeline controller for the 5-stage MIPS core. Merges per-stage stall requests into
//  the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem, mem_wb. Sequences exception
//  and ERET entry: freezes the pipe for one cycle, then pulses flush and redirects the PC.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_if.sv | 23 ++
 rtl/pipe_ctrl_stall_encoder.sv | 21 ++
 rtl/pipe_ctrl.sv | 104 ++++++++++
 tb/tb_pipe_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall masks, exception codes and the
// controller state encoding used by pipe_ctrl and its stall encoder.
package pipe_ctrl_pkg;

  // Stall masks: bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB, 5 = WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [31:0] EXC_ERET       = 32'h0000_000e;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FREEZE   = 2'd2,
    ST_FLUSH    = 2'd3
  } pipe_state_t;

  // Redirect target for an accepted exception: ERET returns to EPC.
  function automatic logic [31:0] exc_target(input logic [31:0] excepttype,
                                             input logic [31:0] epc,
                                             input logic [31:0] vector,
                                             input logic [31:0] eret_code);
    return (excepttype == eret_code) ? epc : vector;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central controller.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  // master: the pipeline stages; slave: the controller
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc
  );
endinterface

// File: rtl/pipe_ctrl_stall_encoder.sv
// Priority encoder turning the four stage stall requests into a stall mask;
// the deepest requesting stage wins because it must hold everything upstream.
module stall_encoder
  import pipe_ctrl_pkg::*;
(
  input  logic       req_if,
  input  logic       req_id,
  input  logic       req_ex,
  input  logic       req_mem,
  output logic [5:0] mask
);

  always_comb begin
    mask = STALL_NONE;
    if (req_mem)     mask = STALL_MEM;
    else if (req_ex) mask = STALL_EX;
    else if (req_id) mask = STALL_ID;
    else if (req_if) mask = STALL_IF;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stall requests, sequences exception/ERET
// entry (freeze one cycle, then flush + redirect) and keeps stall/flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_CODE  = EXC_ERET,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.slave       bus,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [15:0]      flush_count
);

  pipe_state_t state, state_nx;
  logic [5:0]  req_mask;
  logic [5:0]  stall_mask;
  logic        flush_now;
  logic        capture;
  logic        has_exc;
  logic [31:0] target;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  stall_encoder u_enc (
    .req_if  (bus.stallreq_if),
    .req_id  (bus.stallreq_id),
    .req_ex  (bus.stallreq_ex),
    .req_mem (bus.stallreq_mem),
    .mask    (req_mask)
  );

  assign has_exc = (bus.excepttype_i != 32'd0);

  always_comb begin
    state_nx   = state;
    stall_mask = req_mask;
    flush_now  = 1'b0;
    capture    = 1'b0;
    unique case (state)
      ST_RUN, ST_WAIT_MEM: begin
        // The faulting instruction's bus transaction always completes first.
        if (!has_exc) begin
          state_nx = ST_RUN;
        end else if (bus.stallreq_mem) begin
          state_nx = ST_WAIT_MEM;
        end else begin
          capture    = 1'b1;
          stall_mask = STALL_ALL;
          state_nx   = ST_FREEZE;
        end
      end
      ST_FREEZE: begin
        stall_mask = STALL_ALL;
        state_nx   = ST_FLUSH;
      end
      ST_FLUSH: begin
        stall_mask = STALL_NONE;
        flush_now  = 1'b1;
        state_nx   = ST_RUN;
      end
      default: begin
        state_nx = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nx;
  end

  assign target = exc_target(bus.excepttype_i, bus.cp0_epc_i, EXC_VECTOR, ERET_CODE);

  always_ff @(posedge clk) begin
    if (rst)          bus.new_pc <= 32'd0;
    else if (capture) bus.new_pc <= target;
  end

  // Counters: stall cycles only while the pipe runs normally, flushes per pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= 16'd0;
    end else begin
      if ((state == ST_RUN || state == ST_WAIT_MEM) && stall_mask[0])
        stall_cycles <= sat_inc_cnt(stall_cycles);
      if (flush_now)
        flush_count <= sat_inc16(flush_count);
    end
  end

  assign bus.stall = stall_mask;
  assign bus.flush = flush_now;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic, checked
// against a cycle-level behavioural model built from a queue of forced slots.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if pif ();
  pipe_ctrl_if pif_s ();

  logic [31:0] cyc;
  logic [15:0] fcnt;
  logic [2:0]  cyc_s;
  logic [15:0] fcnt_s;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(pif.slave), .stall_cycles(cyc), .flush_count(fcnt)
  );

  // Narrow-counter copy sees identical inputs; exposes counter saturation quickly
  pipe_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .bus(pif_s.slave), .stall_cycles(cyc_s), .flush_count(fcnt_s)
  );

  assign pif_s.stallreq_if  = pif.stallreq_if;
  assign pif_s.stallreq_id  = pif.stallreq_id;
  assign pif_s.stallreq_ex  = pif.stallreq_ex;
  assign pif_s.stallreq_mem = pif.stallreq_mem;
  assign pif_s.excepttype_i = pif.excepttype_i;
  assign pif_s.cp0_epc_i    = pif.cp0_epc_i;

  typedef struct {
    logic [5:0] stall;
    logic       flush;
  } slot_t;

  slot_t       sched[$];
  logic [31:0] m_tgt;
  longint      m_cycles;
  int          m_flushes;

  int errors = 0;
  int checks = 0;

  logic [5:0]  obs_stall;
  logic        obs_flush;
  logic [31:0] obs_pc;
  logic [31:0] obs_cyc;
  logic [15:0] obs_fcnt;
  logic [2:0]  obs_cyc_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sched.delete();
    m_tgt     = 32'd0;
    m_cycles  = 0;
    m_flushes = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pif.stallreq_if  = 1'b0;
    pif.stallreq_id  = 1'b0;
    pif.stallreq_ex  = 1'b0;
    pif.stallreq_mem = 1'b0;
    pif.excepttype_i = 32'd0;
    pif.cp0_epc_i    = 32'd0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem,
                      input logic [31:0] exc, input logic [31:0] epc);
    logic [5:0] e_stall;
    logic       e_flush;
    logic       busy;
    logic       accept;
    pif.stallreq_if  = i_if;
    pif.stallreq_id  = i_id;
    pif.stallreq_ex  = i_ex;
    pif.stallreq_mem = i_mem;
    pif.excepttype_i = exc;
    pif.cp0_epc_i    = epc;
    @(negedge clk);
    busy    = (sched.size() > 0);
    accept  = 1'b0;
    e_flush = 1'b0;
    if (busy) begin
      e_stall = sched[0].stall;
      e_flush = sched[0].flush;
    end else begin
      e_stall = i_mem ? 6'h1f : i_ex ? 6'h0f : i_id ? 6'h07 : i_if ? 6'h03 : 6'h00;
      if (exc != 32'd0 && !i_mem) begin
        e_stall = 6'h3f;
        accept  = 1'b1;
      end
    end
    chk("stall", {58'd0, pif.stall}, {58'd0, e_stall});
    chk("flush", {63'd0, pif.flush}, {63'd0, e_flush});
    if (e_flush) chk("new_pc", {32'd0, pif.new_pc}, {32'd0, m_tgt});
    chk("stall_cycles", {32'd0, cyc}, m_cycles);
    chk("stall_cycles_narrow", {61'd0, cyc_s}, (m_cycles > 7) ? 64'd7 : m_cycles);
    chk("flush_count", {48'd0, fcnt}, 64'(m_flushes));
    chk("flush_count_narrow", {48'd0, fcnt_s}, 64'(m_flushes));
    obs_stall = pif.stall;
    obs_flush = pif.flush;
    obs_pc    = pif.new_pc;
    obs_cyc   = cyc;
    obs_fcnt  = fcnt;
    obs_cyc_s = cyc_s;
    @(posedge clk);
    if (busy) begin
      if (e_flush && m_flushes < 65535) m_flushes++;
      void'(sched.pop_front());
    end else begin
      if (e_stall[0] && m_cycles < 64'hffff_ffff) m_cycles++;
      if (accept) begin
        m_tgt = (exc == 32'h0000_000e) ? epc : 32'h0000_0020;
        sched.push_back('{stall: 6'h3f, flush: 1'b0});
        sched.push_back('{stall: 6'h00, flush: 1'b1});
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    do_reset();
    do_reset();

    // Reset state
    step(0, 0, 0, 0, 32'd0, 32'd0);
    chk("rst_stall", {58'd0, obs_stall}, 64'd0);
    chk("rst_new_pc", {32'd0, obs_pc}, 64'd0);
    chk("rst_cycles", {32'd0, obs_cyc}, 64'd0);

    // Deepest request wins
    step(0, 1, 1, 0, 32'd0, 32'd0);
    chk("t1_id_ex", {58'd0, obs_stall}, 64'h0f);
    step(0, 0, 0, 0, 32'd0, 32'd0);
    chk("t1_none", {58'd0, obs_stall}, 64'h00);

    // General exception: accept, freeze, flush to vector
    step(0, 0, 0, 0, 32'h1, 32'd0);
    chk("t2_accept", {58'd0, obs_stall}, 64'h3f);
    step(0, 0, 0, 0, 32'd0, 32'd0);
    chk("t2_freeze", {58'd0, obs_stall}, 64'h3f);
    chk("t2_nofl", {63'd0, obs_flush}, 64'd0);
    step(1, 1, 1, 1, 32'd0, 32'd0);
    chk("t2_flush", {63'd0, obs_flush}, 64'd1);
    chk("t2_pc", {32'd0, obs_pc}, 64'h20);
    chk("t2_flush_stall", {58'd0, obs_stall}, 64'h00);
    step(0, 0, 0, 0, 32'd0, 32'd0);
    chk("t2_fcnt", {48'd0, obs_fcnt}, 64'd1);

    // ERET returns to EPC
    step(0, 0, 0, 0, 32'he, 32'hbfc0_0100);
    step(0, 0, 0, 0, 32'd0, 32'd0);
    step(0, 0, 0, 0, 32'd0, 32'd0);
    chk("t3_flush", {63'd0, obs_flush}, 64'd1);
    chk("t3_pc", {32'd0, obs_pc}, 64'hbfc0_0100);

    // Exception waits for the MEM bus transaction
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 32'h1, 32'd0);
      chk("t4_wait", {58'd0, obs_stall}, 64'h1f);
      chk("t4_nofl", {63'd0, obs_flush}, 64'd0);
    end
    step(0, 0, 0, 0, 32'h1, 32'd0);
    chk("t4_accept", {58'd0, obs_stall}, 64'h3f);
    step(0, 0, 0, 0, 32'h1, 32'd0);
    chk("t4_freeze", {63'd0, obs_flush}, 64'd0);
    step(0, 0, 0, 0, 32'd0, 32'd0);
    chk("t4_flush", {63'd0, obs_flush}, 64'd1);

    // Reset while frozen
    step(0, 0, 0, 0, 32'h1, 32'd0);
    do_reset();
    step(0, 0, 0, 0, 32'd0, 32'd0);
    chk("t5_flush", {63'd0, obs_flush}, 64'd0);
    chk("t5_stall", {58'd0, obs_stall}, 64'd0);
    chk("t5_cycles", {32'd0, obs_cyc}, 64'd0);
    chk("t5_fcnt", {48'd0, obs_fcnt}, 64'd0);

    // Counter saturation on the narrow instance
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 32'd0, 32'd0);
    step(0, 0, 0, 0, 32'd0, 32'd0);
    chk("t6_sat", {61'd0, obs_cyc_s}, 64'd7);
    chk("t6_wide", {32'd0, obs_cyc}, 64'd10);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] exc;
      int r;
      r = $urandom_range(0, 11);
      exc = (r == 0) ? 32'h1 : (r == 1) ? 32'he : (r == 2) ? ($urandom() | 32'h1) : 32'd0;
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0, exc, $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
